// File: rtl/btb_ctrl_pkg.sv
// btb_ctrl_pkg: state type and small helpers shared by the BTB controller.
// No ports; sizing and encodings come from defines.vh.
`include "defines.vh"

package btb_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = `BTB_ST_IDLE,
    ST_PROBE = `BTB_ST_PROBE,
    ST_WRITE = `BTB_ST_WRITE,
    ST_FLUSH = `BTB_ST_FLUSH
  } btb_state_e;

  // Next line index; wraps from the last line back to line 0.
  function automatic logic [`BTB_LINE_SIZE-1:0] line_inc(input logic [`BTB_LINE_SIZE-1:0] l);
    return l + {{(`BTB_LINE_SIZE-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/btb_victim_select.sv
// btb_victim_select: lowest-index invalid line finder.
// Ports: valid (per-line valid vector) -> any_invalid (some line free),
//        line (lowest free line index, 0 when none is free).
`include "defines.vh"

module btb_victim_select (
  input  logic [`BTB_LINE_NUM-1:0]  valid,
  output logic                      any_invalid,
  output logic [`BTB_LINE_SIZE-1:0] line
);

  // Scan from the top down so the lowest free index is the last one kept.
  always_comb begin
    any_invalid = 1'b0;
    line        = '0;
    for (int i = `BTB_LINE_NUM - 1; i >= 0; i--) begin
      any_invalid = any_invalid | ~valid[i];
      line        = valid[i] ? line : i[`BTB_LINE_SIZE-1:0];
    end
  end

endmodule

// File: rtl/defines.vh
// Shared BTB sizing and controller state encodings.
`ifndef BTB_DEFINES_VH
`define BTB_DEFINES_VH

`define BTB_TAG_SIZE    8
`define BTB_LINE_SIZE   3
`define BTB_LINE_NUM    8
`define BTB_TARGET_SIZE 16

`define BTB_ST_IDLE  2'd0
`define BTB_ST_PROBE 2'd1
`define BTB_ST_WRITE 2'd2
`define BTB_ST_FLUSH 2'd3

`endif

// File: rtl/btb_ctrl.sv
// btb_ctrl: branch target buffer controller arbitrating one external
// associative comparator between fetch lookups, updates and a flush sweep.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   lookup_valid/lookup_tag          fetch lookup request
//   lookup_ready/pred_hit/pred_line  zero-latency lookup result (IDLE only)
//   update_req/tag/target, update_ack  level update request, 1-cycle ack
//   flush_req, flush_done            invalidate-all pulse and completion pulse
//   cmp_tag, cmp_hit, cmp_line       external comparator interface
//   valid                            per-line valid vector to the comparator
//   wr_en/wr_line/wr_tag/wr_target   tag/target storage write port
`include "defines.vh"

module btb_ctrl
  import btb_ctrl_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        lookup_valid,
  input  logic [`BTB_TAG_SIZE-1:0]    lookup_tag,
  output logic                        lookup_ready,
  output logic                        pred_hit,
  output logic [`BTB_LINE_SIZE-1:0]   pred_line,
  input  logic                        update_req,
  input  logic [`BTB_TAG_SIZE-1:0]    update_tag,
  input  logic [`BTB_TARGET_SIZE-1:0] update_target,
  output logic                        update_ack,
  input  logic                        flush_req,
  output logic                        flush_done,
  output logic [`BTB_TAG_SIZE-1:0]    cmp_tag,
  input  logic                        cmp_hit,
  input  logic [`BTB_LINE_SIZE-1:0]   cmp_line,
  output logic [`BTB_LINE_NUM-1:0]    valid,
  output logic                        wr_en,
  output logic [`BTB_LINE_SIZE-1:0]   wr_line,
  output logic [`BTB_TAG_SIZE-1:0]    wr_tag,
  output logic [`BTB_TARGET_SIZE-1:0] wr_target
);

  btb_state_e                 state_r, state_s;
  logic [`BTB_LINE_NUM-1:0]   valid_r;
  logic [`BTB_LINE_SIZE-1:0]  rr_ptr_r;
  logic [`BTB_LINE_SIZE-1:0]  sweep_r;
  logic                       flush_pend_r;
  logic                       probe_hit_r;
  logic [`BTB_LINE_SIZE-1:0]  probe_line_r;
  logic                       any_invalid_s;
  logic [`BTB_LINE_SIZE-1:0]  victim_line_s;
  logic [`BTB_LINE_SIZE-1:0]  wr_line_s;
  logic                       evict_s;
  logic                       flush_go_s;

  btb_victim_select u_victim (
    .valid       (valid_r),
    .any_invalid (any_invalid_s),
    .line        (victim_line_s)
  );

  // A latched flush behaves exactly like a fresh flush_req seen in IDLE.
  assign flush_go_s = flush_req | flush_pend_r;

  // Replacement choice: reuse the hit line, else fill a hole, else evict round-robin.
  always_comb begin
    wr_line_s = rr_ptr_r;
    evict_s   = 1'b0;
    if (probe_hit_r) begin
      wr_line_s = probe_line_r;
    end else if (any_invalid_s) begin
      wr_line_s = victim_line_s;
    end else begin
      wr_line_s = rr_ptr_r;
      evict_s   = 1'b1;
    end
  end

  // Next-state and per-state outputs; the comparator is owned by one requester per cycle.
  always_comb begin
    state_s      = state_r;
    cmp_tag      = lookup_tag;
    lookup_ready = 1'b0;
    pred_hit     = 1'b0;
    wr_en        = 1'b0;
    update_ack   = 1'b0;
    flush_done   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (flush_go_s) begin
          state_s = ST_FLUSH;
        end else if (update_req) begin
          state_s = ST_PROBE;
          cmp_tag = update_tag;
        end else begin
          lookup_ready = 1'b1;
          pred_hit     = lookup_valid & cmp_hit;
        end
      end
      ST_PROBE: begin
        cmp_tag = update_tag;
        state_s = ST_WRITE;
      end
      ST_WRITE: begin
        cmp_tag    = update_tag;
        wr_en      = 1'b1;
        update_ack = 1'b1;
        state_s    = ST_IDLE;
      end
      ST_FLUSH: begin
        if (&sweep_r) begin
          flush_done = 1'b1;
          state_s    = ST_IDLE;
        end else begin
          state_s = ST_FLUSH;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  assign pred_line = cmp_line;
  assign valid     = valid_r;
  assign wr_line   = wr_line_s;
  assign wr_tag    = update_tag;
  assign wr_target = update_target;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Valid bits, replacement pointer, sweep counter, pending flush and probe results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r      <= '0;
      rr_ptr_r     <= '0;
      sweep_r      <= '0;
      flush_pend_r <= 1'b0;
      probe_hit_r  <= 1'b0;
      probe_line_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (flush_go_s) begin
            sweep_r      <= '0;
            flush_pend_r <= 1'b0;
          end
        end
        ST_PROBE: begin
          probe_hit_r  <= cmp_hit;
          probe_line_r <= cmp_line;
          if (flush_req) flush_pend_r <= 1'b1;
        end
        ST_WRITE: begin
          valid_r[wr_line_s] <= 1'b1;
          if (evict_s) rr_ptr_r <= line_inc(rr_ptr_r);
          if (flush_req) flush_pend_r <= 1'b1;
        end
        ST_FLUSH: begin
          // flush_req is deliberately not sampled here: a flush during a flush is redundant.
          valid_r[sweep_r] <= 1'b0;
          sweep_r          <= line_inc(sweep_r);
          if (&sweep_r) rr_ptr_r <= '0;
        end
        default: begin
          sweep_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btb_ctrl.sv
// Testbench for btb_ctrl: models the external comparator, scoreboards writes,
// runs a lookup vector table and hand-written update/flush/reset sequences.
`include "defines.vh"

module tb_btb_ctrl;

  localparam int TW = `BTB_TAG_SIZE;
  localparam int LW = `BTB_LINE_SIZE;
  localparam int LN = `BTB_LINE_NUM;
  localparam int GW = `BTB_TARGET_SIZE;

  logic          clk, rst_n;
  logic          lookup_valid;
  logic [TW-1:0] lookup_tag;
  logic          lookup_ready, pred_hit;
  logic [LW-1:0] pred_line;
  logic          update_req;
  logic [TW-1:0] update_tag;
  logic [GW-1:0] update_target;
  logic          update_ack;
  logic          flush_req, flush_done;
  logic [TW-1:0] cmp_tag;
  logic          cmp_hit;
  logic [LW-1:0] cmp_line;
  logic [LN-1:0] valid;
  logic          wr_en;
  logic [LW-1:0] wr_line;
  logic [TW-1:0] wr_tag;
  logic [GW-1:0] wr_target;

  btb_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .lookup_valid(lookup_valid), .lookup_tag(lookup_tag),
    .lookup_ready(lookup_ready), .pred_hit(pred_hit), .pred_line(pred_line),
    .update_req(update_req), .update_tag(update_tag), .update_target(update_target),
    .update_ack(update_ack),
    .flush_req(flush_req), .flush_done(flush_done),
    .cmp_tag(cmp_tag), .cmp_hit(cmp_hit), .cmp_line(cmp_line),
    .valid(valid),
    .wr_en(wr_en), .wr_line(wr_line), .wr_tag(wr_tag), .wr_target(wr_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // External associative comparator model with its own tag store.
  logic [TW-1:0] tag_mem [LN];
  initial for (int i = 0; i < LN; i++) tag_mem[i] = '0;
  always @(posedge clk) if (wr_en) tag_mem[wr_line] <= wr_tag;
  always_comb begin
    cmp_hit  = 1'b0;
    cmp_line = '0;
    for (int i = 0; i < LN; i++) begin
      if (valid[i] && tag_mem[i] == cmp_tag) begin
        cmp_hit  = 1'b1;
        cmp_line = i[LW-1:0];
      end
    end
  end

  // Write scoreboard: expectations pushed when an update is driven.
  typedef struct packed {
    logic [LW-1:0] line;
    logic [TW-1:0] tag;
    logic [GW-1:0] target;
  } wr_exp_t;
  wr_exp_t exp_q[$];

  always @(negedge clk) begin
    wr_exp_t e;
    if (rst_n && wr_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_line", 32'(wr_line), 32'(e.line));
        check("wr_tag", 32'(wr_tag), 32'(e.tag));
        check("wr_target", 32'(wr_target), 32'(e.target));
        check("ack_with_write", 32'(update_ack), 32'd1);
      end
    end
  end

  // One update from IDLE; lookups must be blocked while it is in flight.
  task automatic do_update(input logic [TW-1:0] tag, input logic [GW-1:0] tgt, input logic [LW-1:0] line);
    int n;
    bit got;
    @(negedge clk);
    update_req    = 1'b1;
    update_tag    = tag;
    update_target = tgt;
    exp_q.push_back({line, tag, tgt});
    n   = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      check("upd_lookup_ready", 32'(lookup_ready), 32'd0);
      check("upd_pred_hit", 32'(pred_hit), 32'd0);
      if (update_ack) got = 1'b1;
    end
    check("ack_latency", 32'(n), 32'd2);
    update_req = 1'b0;
  endtask

  typedef struct {
    logic          lv;
    logic [TW-1:0] tag;
    logic          ehit;
    logic [LW-1:0] eline;
  } lk_vec_t;
  lk_vec_t lk_tab[6];

  initial begin
    #200000;
    $display("FAIL timeout: got 0x0 expected 0x1");
    $fatal(1, "timeout");
  end

  initial begin
    int done_cyc, done_cnt, ack_cyc;

    lk_tab[0] = '{1'b1, 8'h15, 1'b1, 3'd5};
    lk_tab[1] = '{1'b1, 8'h10, 1'b1, 3'd0};
    lk_tab[2] = '{1'b1, 8'h17, 1'b1, 3'd7};
    lk_tab[3] = '{1'b1, 8'h99, 1'b0, 3'd0};
    lk_tab[4] = '{1'b0, 8'h12, 1'b0, 3'd2};
    lk_tab[5] = '{1'b1, 8'h13, 1'b1, 3'd3};

    rst_n = 1'b0; lookup_valid = 1'b1; lookup_tag = 8'h15;
    update_req = 1'b0; update_tag = '0; update_target = '0; flush_req = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_pred_hit", 32'(pred_hit), 32'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", 32'(lookup_ready), 32'd1);
    check("post_rst_cmp_tag", 32'(cmp_tag), 32'h15);
    check("post_rst_ack", 32'(update_ack), 32'd0);
    check("post_rst_done", 32'(flush_done), 32'd0);

    // Fill an empty BTB: lines 0..7 in order.
    for (int i = 0; i < 8; i++) do_update(8'(8'h10 + i), 16'(16'h1000 + i), i[LW-1:0]);
    @(negedge clk);
    check("valid_full", 32'(valid), 32'hFF);

    // Lookup vector table in IDLE.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      lookup_valid = lk_tab[i].lv;
      lookup_tag   = lk_tab[i].tag;
      #1;
      check("lk_ready", 32'(lookup_ready), 32'd1);
      check("lk_cmp_tag", 32'(cmp_tag), 32'(lk_tab[i].tag));
      check("lk_pred_hit", 32'(pred_hit), 32'(lk_tab[i].ehit));
      check("lk_pred_line", 32'(pred_line), 32'(lk_tab[i].eline));
    end
    lookup_valid = 1'b1; lookup_tag = 8'h15;

    // Hit re-write, then round-robin eviction from pointer 0.
    do_update(8'h13, 16'h2013, 3'd3);
    do_update(8'h20, 16'h2020, 3'd0);
    do_update(8'h21, 16'h2021, 3'd1);

    // Flush and update together; a second flush pulse mid-sweep is ignored.
    @(negedge clk);
    flush_req = 1'b1; update_req = 1'b1; update_tag = 8'h30; update_target = 16'h3000;
    exp_q.push_back({3'd0, 8'h30, 16'h3000});
    done_cyc = -1; done_cnt = 0; ack_cyc = -1;
    for (int c = 1; c <= 30 && ack_cyc < 0; c++) begin
      @(negedge clk);
      if (c == 1) flush_req = 1'b0;
      if (c == 3) flush_req = 1'b1;
      if (c == 4) flush_req = 1'b0;
      if (flush_done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (c == 9) check("flush_valid_clear", 32'(valid), 32'd0);
      if (update_ack) ack_cyc = c;
    end
    update_req = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (flush_done) done_cnt++;
    end
    check("flush_done_cycle", 32'(done_cyc), 32'd8);
    check("flush_done_count", 32'(done_cnt), 32'd1);
    check("flush_then_ack_cycle", 32'(ack_cyc), 32'd11);
    check("flush_then_valid", 32'(valid), 32'h01);

    // Flush pulsed during PROBE: update acks first, flush follows.
    @(negedge clk);
    update_req = 1'b1; update_tag = 8'h31; update_target = 16'h3100;
    exp_q.push_back({3'd1, 8'h31, 16'h3100});
    done_cyc = -1; ack_cyc = -1;
    for (int c = 1; c <= 30 && done_cyc < 0; c++) begin
      @(negedge clk);
      if (c == 1) flush_req = 1'b1;
      if (c == 2) flush_req = 1'b0;
      if (update_ack) begin
        ack_cyc = c;
        update_req = 1'b0;
      end
      if (flush_done) done_cyc = c;
    end
    check("pend_ack_cycle", 32'(ack_cyc), 32'd2);
    check("pend_done_cycle", 32'(done_cyc), 32'd11);
    @(negedge clk);
    check("pend_valid_clear", 32'(valid), 32'd0);

    // Reset during the WRITE of line 4 abandons the update.
    for (int i = 0; i < 4; i++) do_update(8'(8'h40 + i), 16'(16'h4000 + i), i[LW-1:0]);
    @(negedge clk);
    update_req = 1'b1; update_tag = 8'h44; update_target = 16'h4400;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_mid_in_write", 32'(wr_en), 32'd1);
    check("rst_mid_line", 32'(wr_line), 32'd4);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ack", 32'(update_ack), 32'd0);
    check("rst_mid_wr_en", 32'(wr_en), 32'd0);
    check("rst_mid_valid4", 32'(valid[4]), 32'd0);
    @(negedge clk);
    update_req = 1'b0; lookup_tag = 8'h22;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_ready", 32'(lookup_ready), 32'd1);
    check("rel_cmp_tag", 32'(cmp_tag), 32'h22);
    ack_cyc = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (update_ack) ack_cyc++;
    end
    check("rel_no_ack", 32'(ack_cyc), 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/btb_ctrl.md
BTB_CTRL -- requirements
Module: btb_ctrl

Interface
REQ-001 SHALL take parameters from defines.vh only: BTB_TAG_SIZE tag width; BTB_LINE_SIZE line-index width, 3; BTB_LINE_NUM line count, 8; BTB_TARGET_SIZE target width.
REQ-002 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-003 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports: lookup_valid  in  1  fetch lookup request; lookup_tag  in  BTB_TAG_SIZE  fetch tag.
REQ-005 SHALL have ports: lookup_ready  out  1  lookup is being served this cycle; pred_hit  out  1  lookup hit; pred_line  out  BTB_LINE_SIZE  hit line.
REQ-006 SHALL have ports: update_req  in  1  update request, level, held until ack; update_tag  in  BTB_TAG_SIZE; update_target  in  BTB_TARGET_SIZE; update_ack  out  1  one-cycle completion pulse.
REQ-007 SHALL have ports: flush_req  in  1  invalidate-all request, pulse; flush_done  out  1  one-cycle pulse when the sweep ends.
REQ-008 SHALL have ports: cmp_tag  out  BTB_TAG_SIZE  tag driven to the shared associative comparator; cmp_hit  in  1; cmp_line  in  BTB_LINE_SIZE  comparator results.
REQ-009 SHALL have ports: valid  out  BTB_LINE_NUM  per-line valid vector, fed to comparator valid0..7.
REQ-010 SHALL have ports: wr_en  out  1; wr_line  out  BTB_LINE_SIZE; wr_tag  out  BTB_TAG_SIZE; wr_target  out  BTB_TARGET_SIZE  write port to tag/target storage.

Function
REQ-011 SHALL implement FSM states IDLE, PROBE, WRITE, FLUSH.
REQ-012 Priority in IDLE SHALL be: flush_req > update_req > lookup; exactly one requester owns the comparator per cycle.
REQ-013 In IDLE with no flush_req/update_req, cmp_tag SHALL equal lookup_tag and lookup_ready SHALL be 1; pred_hit = lookup_valid & cmp_hit and pred_line = cmp_line, combinational, zero latency.
REQ-014 In every state other than a serving IDLE cycle, lookup_ready and pred_hit SHALL be 0.
REQ-015 IDLE with update_req and no flush_req SHALL go to PROBE; PROBE SHALL drive cmp_tag = update_tag and register cmp_hit/cmp_line.
REQ-016 PROBE SHALL go to WRITE unconditionally; in WRITE, wr_en = 1, wr_tag = update_tag, wr_target = update_target, update_ack = 1; the next state is IDLE.
REQ-017 wr_line SHALL be: the registered cmp_line on a probe hit; else the lowest-index invalid line; else the round-robin pointer.
REQ-018 The round-robin pointer SHALL advance by 1, modulo 8 with 7 wrapping to 0, only when WRITE evicts a valid line chosen by the pointer.
REQ-019 valid[wr_line] SHALL be set at the clock edge ending WRITE; update latency SHALL be exactly 2 cycles from acceptance to ack.
REQ-020 IDLE with flush_req SHALL go to FLUSH with a sweep counter of 0.
REQ-021 FLUSH SHALL clear valid[counter] each cycle for 8 cycles (lines 0..7) and assert flush_done on the cycle that clears line 7, then go to IDLE; the round-robin pointer SHALL reset to 0 on that cycle.
REQ-022 A flush_req arriving in PROBE/WRITE SHALL be latched pending and served from IDLE immediately after the update completes.
REQ-023 A flush_req arriving during FLUSH SHALL be ignored.
REQ-024 update_req held during FLUSH SHALL be accepted only after FLUSH returns to IDLE.
REQ-025 wr_en, update_ack and flush_done SHALL be 0 outside the states named above.

Reset
REQ-026 rst_n low SHALL asynchronously force: state IDLE, valid all 0, round-robin pointer 0, sweep counter 0, flush pending 0, registered probe results 0, and wr_en, update_ack, flush_done, pred_hit 0.
REQ-027 Reset asserted mid-PROBE/WRITE/FLUSH SHALL abandon the operation without a write; no ack is issued.
REQ-028 In the first cycle after reset release, the block SHALL be in IDLE, with lookup_ready = 1 and cmp_tag = lookup_tag.

Structure
REQ-029 BTB_TAG_SIZE, BTB_LINE_SIZE, BTB_LINE_NUM, BTB_TARGET_SIZE and state encodings SHALL live in defines.vh; none SHALL be redefined locally.
REQ-030 The lowest-invalid-line priority encoder SHALL be one sub-module, btb_victim_select, with inputs valid[7:0] and outputs any_invalid and line[2:0].
REQ-031 The associative comparator SHALL stay external; btb_ctrl SHALL only drive its tag/valid and consume hit/line.

Verification
REQ-032 Reset, then 8 updates with tags 0x10..0x17 into an empty BTB -> wr_line 0..7 in order, ack 2 cycles after each acceptance, valid = 0xFF, pointer 0.
REQ-033 Full BTB, update tag 0x13 (present in line 3) -> wr_line 3, pointer unchanged; a 9th new tag 0x20 -> wr_line 0, pointer 1; next new tag 0x21 -> wr_line 1.
REQ-034 Lookup tag 0x15 in IDLE -> same-cycle pred_hit 1, pred_line 5; the same lookup during PROBE -> lookup_ready 0, pred_hit 0.
REQ-035 flush_req and update_req in the same IDLE cycle -> 8 FLUSH cycles, flush_done on cycle 8, valid = 0x00, then update written to line 0.
REQ-036 flush_req pulsed during PROBE -> update acked first, FLUSH starts the cycle after return to IDLE.
REQ-037 rst_n low during WRITE of line 4 -> valid[4] = 0, no ack, IDLE after release.
